// File: rtl/ram_req_ctrl_if.sv
// Request/response bundle between a client and the RAM request front-end.
// Both directions use valid/ready: a transfer happens at a posedge where valid && ready;
// the sender holds valid and its payload steady until that edge, and ready may depend on nothing but registered state.
interface ram_req_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] rsp_addr;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_addr
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_addr
    );
endinterface

// File: rtl/ram_req_ctrl.sv
// In-order request front-end for a single-port RAM: queues read/write requests,
// issues them one at a time, times the read latency and returns read data.
module ram_req_ctrl #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              reset,
    ram_req_ctrl_if.slave     bus,
    output logic              ram_write_enb,
    output logic              ram_read_enb,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy,
    output logic [2:0]        state_dbg
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(RD_LAT + 1);
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RSP      = 3'd4
    } state_t;

    state_t state, state_next;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count, count_next;
    logic               req_ready_q;
    logic               push, pop, fifo_empty;
    logic [ENTRY_W-1:0] head;
    logic               head_wr;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_wdata;
    state_t             head_state;

    logic [ADDR_W-1:0]  cur_addr;
    logic [DATA_W-1:0]  cur_wdata;
    logic [CNT_W-1:0]   lat_cnt;
    logic [DATA_W-1:0]  rsp_rdata_q;
    logic [ADDR_W-1:0]  rsp_addr_q;

    // ---------------- command FIFO ----------------
    assign push       = bus.req_valid && req_ready_q;
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];
    assign head_wr    = head[ENTRY_W-1];
    assign head_addr  = head[DATA_W +: ADDR_W];
    assign head_wdata = head[DATA_W-1:0];
    assign head_state = head_wr ? WR_ISSUE : RD_ISSUE;

    always_comb begin
        count_next = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.req_wr, bus.req_addr, bus.req_wdata};
        end
    end

    // req_ready is registered from the post-edge fill level, so it is low in reset
    // and rises on the first edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            req_ready_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count       <= count_next;
            req_ready_q <= (count_next != FULL_CNT);
        end
    end

    // ---------------- issue FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = head_state;
                end
            end
            WR_ISSUE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = head_state;
                end else begin
                    state_next = IDLE;
                end
            end
            RD_ISSUE: begin
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (lat_cnt == CNT_W'(1)) begin
                    state_next = RSP;
                end
            end
            RSP: begin
                // Nothing behind a read is issued until its response is taken.
                if (bus.rsp_ready) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = head_state;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_addr    <= '0;
            cur_wdata   <= '0;
            lat_cnt     <= '0;
            rsp_rdata_q <= '0;
            rsp_addr_q  <= '0;
        end else begin
            if (pop) begin
                cur_addr <= head_addr;
                // Reads leave the RAM data bus at its last written value.
                if (head_wr) begin
                    cur_wdata <= head_wdata;
                end
            end
            if (state == RD_ISSUE) begin
                lat_cnt <= LAT_LOAD;
            end else if (state == RD_WAIT) begin
                lat_cnt <= lat_cnt - CNT_W'(1);
            end
            if ((state == RD_WAIT) && (lat_cnt == CNT_W'(1))) begin
                rsp_rdata_q <= ram_data_out;
                rsp_addr_q  <= cur_addr;
            end
        end
    end

    assign ram_write_enb = (state == WR_ISSUE);
    assign ram_read_enb  = (state == RD_ISSUE);
    assign ram_address   = cur_addr;
    assign ram_data_in   = cur_wdata;

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = (state == RSP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_addr  = rsp_addr_q;

    assign busy      = !fifo_empty || (state != IDLE);
    assign state_dbg = state;
endmodule

// File: tb/tb_ram_req_ctrl.sv
// Bench for ram_req_ctrl: directed requests against a behavioural RAM, with a
// response scoreboard and a RAM-write scoreboard fed by the driver tasks.
module tb_ram_req_ctrl;
    localparam int DW = 8;
    localparam int AW = 3;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT (RD_LAT=1) and its RAM ----------------
    ram_req_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bif ();
    logic          wen, ren, busy;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdin, rdout;
    logic [2:0]    st;

    ram_req_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(4), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .bus(bif),
        .ram_write_enb(wen), .ram_read_enb(ren), .ram_address(raddr),
        .ram_data_in(rdin), .ram_data_out(rdout), .busy(busy), .state_dbg(st)
    );

    logic [DW-1:0] ram1 [8];
    logic [DW-1:0] ram1_q;
    always @(posedge clk) begin
        if (wen) ram1[raddr] <= rdin;
        ram1_q <= ren ? ram1[raddr] : '0;
    end
    assign rdout = ram1_q;

    // ---------------- DUT (RD_LAT=3) and its RAM ----------------
    ram_req_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bif2 ();
    logic          wen2, ren2, busy2;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] rdin2, rdout2;
    logic [2:0]    st2;

    ram_req_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(4), .RD_LAT(3)) dut2 (
        .clk(clk), .reset(reset), .bus(bif2),
        .ram_write_enb(wen2), .ram_read_enb(ren2), .ram_address(raddr2),
        .ram_data_in(rdin2), .ram_data_out(rdout2), .busy(busy2), .state_dbg(st2)
    );

    logic [DW-1:0] ram2 [8];
    logic [DW-1:0] p2 [3];
    always @(posedge clk) begin
        if (wen2) ram2[raddr2] <= rdin2;
        p2[0] <= ren2 ? ram2[raddr2] : '0;
        p2[1] <= p2[0];
        p2[2] <= p2[1];
    end
    assign rdout2 = p2[2];

    // ---------------- scoreboard state ----------------
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] wexp_q[$];
    int checks = 0;
    int errors = 0;
    int pushes = 0;
    int wr_seen = 0;
    int wr_run = 0;
    int max_run = 0;
    int last_acc = 0;
    int last_rd_cyc = 0;
    int rsp_rise_cyc = 0;
    logic stall_prev = 1'b0;
    logic rsp_prev_valid = 1'b0;
    logic [AW+DW-1:0] held = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW-1:0] exp_rd, input bit expect_rsp);
        int n;
        bif.req_valid = 1'b1;
        bif.req_wr    = wr;
        bif.req_addr  = a;
        bif.req_wdata = d;
        if (wr) wexp_q.push_back({a, d});
        else if (expect_rsp) exp_q.push_back({a, exp_rd});
        n = 0;
        @(negedge clk);
        while (!bif.req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!bif.req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_accept timeout addr=%0d", a);
        end
        last_acc = cyc + 1;
        @(posedge clk);
        #1;
        bif.req_valid = 1'b0;
    endtask

    task automatic wr_req(input logic [AW-1:0] a, input logic [DW-1:0] d);
        send_req(1'b1, a, d, '0, 1'b0);
    endtask

    task automatic rd_req(input logic [AW-1:0] a, input logic [DW-1:0] exp_rd);
        send_req(1'b0, a, '0, exp_rd, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0 || wexp_q.size() != 0) && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(name, 32'(n < 200), 32'd1);
        sync();
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [AW+DW-1:0] got, e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stall_prev     = 1'b0;
                rsp_prev_valid = 1'b0;
                wr_run         = 0;
            end else begin
                if (bif.req_valid && bif.req_ready) pushes++;
                if (wen || ren) check("enb_exclusive", 32'(wen && ren), 32'd0);
                if (wen) begin
                    wr_seen++;
                    wr_run++;
                    if (wr_run > max_run) max_run = wr_run;
                    if (wexp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL write_unexpected actual=0x%0h expected=none", {raddr, rdin});
                    end else begin
                        e = wexp_q.pop_front();
                        check("ram_write", {raddr, rdin}, e);
                    end
                end else begin
                    wr_run = 0;
                end
                if (ren) last_rd_cyc = cyc;
                if (bif.rsp_valid && !rsp_prev_valid) rsp_rise_cyc = cyc;
                got = {bif.rsp_addr, bif.rsp_rdata};
                if (stall_prev) begin
                    check("rsp_hold_valid", bif.rsp_valid, 32'd1);
                    check("rsp_hold_data", got, held);
                end
                if (bif.rsp_valid && bif.rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected actual=0x%0h expected=none", got);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_data", got, e);
                    end
                end
                stall_prev     = bif.rsp_valid && !bif.rsp_ready;
                held           = got;
                rsp_prev_valid = bif.rsp_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int acc, p0, w0, n, rd2, rsp2, acc2;
        bit got2;
        bif.req_valid  = 1'b0;
        bif.req_wr     = 1'b0;
        bif.req_addr   = '0;
        bif.req_wdata  = '0;
        bif.rsp_ready  = 1'b1;
        bif2.req_valid = 1'b0;
        bif2.req_wr    = 1'b0;
        bif2.req_addr  = '0;
        bif2.req_wdata = '0;
        bif2.rsp_ready = 1'b1;

        // 1: reset held 3 cycles, all outputs zero; req_ready after first edge
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs", {bif.req_ready, bif.rsp_valid, bif.rsp_rdata, bif.rsp_addr,
                                    wen, ren, raddr, rdin, busy}, 32'd0);
        end
        sync();
        reset = 1'b1;
        @(negedge clk);
        check("req_ready_before_edge", bif.req_ready, 32'd0);
        @(negedge clk);
        check("req_ready_after_edge", bif.req_ready, 32'd1);
        check("busy_after_reset", busy, 32'd0);
        check("state_idle", st, 32'd0);

        // 2: write 0xA5@3 then read @3, with latency check
        sync();
        wr_req(3'd3, 8'hA5);
        rd_req(3'd3, 8'hA5);
        acc = last_acc;
        wait_idle("t2_idle");
        check("t2_read_enb_cycle", last_rd_cyc - acc, 32'd1);
        check("t2_rsp_valid_cycle", rsp_rise_cyc - acc, 32'd3);

        // 3: stalled read fills the FIFO, then 8 writes stream out back-to-back
        max_run = 0;
        bif.rsp_ready = 1'b0;
        p0 = pushes;
        w0 = wr_seen;
        fork
            begin
                rd_req(3'd3, 8'hA5);
                for (int i = 0; i < 8; i++) wr_req(AW'(i), DW'(8'h10 + i));
            end
            begin
                n = 0;
                @(negedge clk);
                while (bif.req_ready && n < 60) begin
                    n++;
                    @(negedge clk);
                end
                check("t3_ready_dropped", bif.req_ready, 32'd0);
                check("t3_pushes_at_full", pushes - p0, 32'd5);
                check("t3_no_write_while_stalled", wr_seen - w0, 32'd0);
                repeat (5) @(negedge clk);
                check("t3_ready_stays_low", bif.req_ready, 32'd0);
                sync();
                bif.rsp_ready = 1'b1;
                n = 0;
                @(negedge clk);
                while (!bif.req_ready && n < 20) begin
                    n++;
                    @(negedge clk);
                end
                check("t3_ready_rises", bif.req_ready, 32'd1);
            end
        join
        wait_idle("t3_idle");
        check("t3_write_stream_len", max_run, 32'd8);

        // 4: read @5 held 10 cycles, write 0x77@5 queued behind it
        bif.rsp_ready = 1'b0;
        rd_req(3'd5, 8'h15);
        wr_req(3'd5, 8'h77);
        n = 0;
        @(negedge clk);
        while (!bif.rsp_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("t4_rsp_valid", bif.rsp_valid, 32'd1);
        w0 = wr_seen;
        repeat (10) @(negedge clk);
        check("t4_write_held", wr_seen - w0, 32'd0);
        check("t4_rsp_still_valid", bif.rsp_valid, 32'd1);
        sync();
        bif.rsp_ready = 1'b1;
        rd_req(3'd5, 8'h77);
        wait_idle("t4_idle");

        // 5: reset during RD_WAIT discards the read
        send_req(1'b0, 3'd2, '0, '0, 1'b0);
        n = 0;
        @(negedge clk);
        while (!ren && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("t5_read_issued", ren, 32'd1);
        sync();
        check("t5_in_rd_wait", st, 32'd3);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_reset_outputs", {bif.req_ready, bif.rsp_valid, wen, ren, busy}, 32'd0);
        sync();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5_no_rsp", bif.rsp_valid, 32'd0);
        end
        check("t5_ready", bif.req_ready, 32'd1);
        check("t5_fifo_empty", busy, 32'd0);
        sync();
        rd_req(3'd2, 8'h12);
        wait_idle("t5_idle");

        // 6: RD_LAT=3 instance, write 0x5C@0 then read @0
        bif2.req_valid = 1'b1;
        bif2.req_wr    = 1'b1;
        bif2.req_addr  = 3'd0;
        bif2.req_wdata = 8'h5C;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            @(negedge clk);
            while (!bif2.req_ready && n < 50) begin
                n++;
                @(negedge clk);
            end
            acc2 = cyc + 1;
            sync();
            bif2.req_wr = 1'b0;
        end
        bif2.req_valid = 1'b0;
        got2 = 1'b0;
        rd2  = 0;
        rsp2 = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ren2) rd2 = cyc;
            if (bif2.rsp_valid && !got2) begin
                got2 = 1'b1;
                rsp2 = cyc;
                check("lat3_rsp_data", {bif2.rsp_addr, bif2.rsp_rdata}, {3'd0, 8'h5C});
            end
        end
        check("lat3_rsp_seen", 32'(got2), 32'd1);
        check("lat3_read_enb_cycle", rd2 - acc2, 32'd1);
        check("lat3_rsp_latency", rsp2 - rd2, 32'd4);
        check("lat3_idle", busy2, 32'd0);

        // ---------------- report ----------------
        check("exp_q_drained", exp_q.size(), 32'd0);
        check("wexp_q_drained", wexp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
